// File: rtl/victim_stage_pkg.sv
// rtl/victim_stage_pkg.sv - shared dcache line geometry and victim stage FSM encoding
package victim_stage_pkg;

  localparam int LINE_WORDS = 8;
  localparam int TAG_W      = 27;
  localparam int OFFSET_W   = 5;
  localparam int LINE_W     = LINE_WORDS * 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CLEAR = 3'd3,
    ST_FDONE = 3'd4
  } vs_state_e;

  function automatic logic [TAG_W-1:0] line_tag(input logic [31:0] paddr);
    return paddr[31:OFFSET_W];
  endfunction

endpackage

// File: rtl/victim_fifo.sv
// rtl/victim_fifo.sv - two-entry victim line queue with merge and refill-forward match
module victim_fifo
  import victim_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_busy,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [TAG_W-1:0]  i_push_tag,
  input  logic [LINE_W-1:0] i_push_data,
  input  logic [TAG_W-1:0]  i_fw_tag,
  output logic              o_merge_ok,
  output logic [1:0]        o_count,
  output logic [TAG_W-1:0]  o_head_tag,
  output logic [LINE_W-1:0] o_head_data,
  output logic              o_fw_hit,
  output logic [LINE_W-1:0] o_fw_data
);

  logic [1:0]        r_valid;
  logic [TAG_W-1:0]  r_tag  [2];
  logic [LINE_W-1:0] r_data [2];
  logic              r_head;
  logic              r_tail;
  logic [1:0]        r_count;

  logic w_young;
  logic w_alloc;
  logic w_wr_idx;
  logic w_fw_young;
  logic w_fw_old;

  // With two slots the non-head entry is always the younger one.
  assign w_young    = ~r_head;
  assign o_merge_ok = i_busy && r_valid[w_young] && (r_tag[w_young] == i_push_tag);
  assign w_alloc    = i_push && !o_merge_ok;
  assign w_wr_idx   = o_merge_ok ? w_young : r_tail;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid <= 2'b00;
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (i_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= ~r_head;
      end
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= ~r_tail;
      end
      r_count <= r_count + {1'b0, w_alloc} - {1'b0, i_pop};
    end
  end

  // Payload is qualified by r_valid everywhere, so it is left unreset.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_tag[w_wr_idx]  <= i_push_tag;
      r_data[w_wr_idx] <= i_push_data;
    end
  end

  assign o_count     = r_count;
  assign o_head_tag  = r_valid[r_head] ? r_tag[r_head]  : '0;
  assign o_head_data = r_valid[r_head] ? r_data[r_head] : '0;

  assign w_fw_young = r_valid[w_young] && (r_tag[w_young] == i_fw_tag);
  assign w_fw_old   = r_valid[r_head]  && (r_tag[r_head]  == i_fw_tag);

  always_comb begin
    o_fw_hit  = w_fw_young || w_fw_old;
    o_fw_data = '0;
    if (w_fw_young) begin
      o_fw_data = r_data[w_young];
    end else if (w_fw_old) begin
      o_fw_data = r_data[r_head];
    end
  end

endmodule

// File: rtl/victim_stage.sv
// rtl/victim_stage.sv - dcache dirty-victim staging between eviction and the write buffer
module victim_stage
  import victim_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              evict_valid,
  output logic              evict_ready,
  input  logic [31:0]       evict_paddr,
  input  logic [LINE_W-1:0] evict_data,
  output logic              wb_wreq,
  input  logic              wb_wreq_recvd,
  input  logic              wb_wdone,
  output logic [31:0]       wb_wdata_paddr,
  output logic [31:0]       wb_wdata_bank0,
  output logic [31:0]       wb_wdata_bank1,
  output logic [31:0]       wb_wdata_bank2,
  output logic [31:0]       wb_wdata_bank3,
  output logic [31:0]       wb_wdata_bank4,
  output logic [31:0]       wb_wdata_bank5,
  output logic [31:0]       wb_wdata_bank6,
  output logic [31:0]       wb_wdata_bank7,
  output logic              wb_clear,
  input  logic              wb_clear_done,
  input  logic              flush_req,
  output logic              flush_done,
  input  logic [31:0]       fw_paddr,
  output logic              fw_hit,
  output logic [LINE_W-1:0] fw_data
);

  vs_state_e r_state;
  logic      r_wb_wreq;
  logic      r_wb_clear;
  logic      r_flush_done;

  logic              w_push;
  logic              w_pop;
  logic              w_busy;
  logic              w_merge_ok;
  logic [1:0]        w_count;
  logic [TAG_W-1:0]  w_head_tag;
  logic [LINE_W-1:0] w_head_data;
  logic              w_unused_offsets;

  assign w_busy      = (r_state != ST_IDLE);
  assign evict_ready = ((w_count < 2'd2) || w_merge_ok) && !flush_req;
  assign w_push      = evict_valid && evict_ready;
  assign w_pop       = (r_state == ST_WAIT) && wb_wdone;

  assign w_unused_offsets = &{1'b0, evict_paddr[OFFSET_W-1:0], fw_paddr[OFFSET_W-1:0]};

  victim_fifo u_fifo (
    .clk         (clk),
    .rstn        (rstn),
    .i_busy      (w_busy),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_push_tag  (line_tag(evict_paddr)),
    .i_push_data (evict_data),
    .i_fw_tag    (line_tag(fw_paddr)),
    .o_merge_ok  (w_merge_ok),
    .o_count     (w_count),
    .o_head_tag  (w_head_tag),
    .o_head_data (w_head_data),
    .o_fw_hit    (fw_hit),
    .o_fw_data   (fw_data)
  );

  // Staged lines drain ahead of wb_clear because IDLE checks count before flush_req.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= ST_IDLE;
      r_wb_wreq    <= 1'b0;
      r_wb_clear   <= 1'b0;
      r_flush_done <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_count != 2'd0) begin
            r_state   <= ST_REQ;
            r_wb_wreq <= 1'b1;
          end else if (flush_req) begin
            r_state    <= ST_CLEAR;
            r_wb_clear <= 1'b1;
          end
        end
        ST_REQ: begin
          if (wb_wreq_recvd) begin
            r_state   <= ST_WAIT;
            r_wb_wreq <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (wb_wdone) begin
            r_state <= ST_IDLE;
          end
        end
        ST_CLEAR: begin
          if (wb_clear_done) begin
            r_state      <= ST_FDONE;
            r_wb_clear   <= 1'b0;
            r_flush_done <= 1'b1;
          end
        end
        ST_FDONE: begin
          r_state      <= ST_IDLE;
          r_flush_done <= 1'b0;
        end
        default: begin
          r_state      <= ST_IDLE;
          r_wb_wreq    <= 1'b0;
          r_wb_clear   <= 1'b0;
          r_flush_done <= 1'b0;
        end
      endcase
    end
  end

  assign wb_wreq        = r_wb_wreq;
  assign wb_clear       = r_wb_clear;
  assign flush_done     = r_flush_done;
  assign wb_wdata_paddr = {w_head_tag, {OFFSET_W{1'b0}}};
  assign wb_wdata_bank0 = w_head_data[0*32 +: 32];
  assign wb_wdata_bank1 = w_head_data[1*32 +: 32];
  assign wb_wdata_bank2 = w_head_data[2*32 +: 32];
  assign wb_wdata_bank3 = w_head_data[3*32 +: 32];
  assign wb_wdata_bank4 = w_head_data[4*32 +: 32];
  assign wb_wdata_bank5 = w_head_data[5*32 +: 32];
  assign wb_wdata_bank6 = w_head_data[6*32 +: 32];
  assign wb_wdata_bank7 = w_head_data[7*32 +: 32];

endmodule

// File: tb/tb_victim_stage.sv
// tb/tb_victim_stage.sv - directed self-checking bench for victim_stage
module tb_victim_stage;

  logic         clk = 1'b0;
  logic         rstn;
  logic         evict_valid;
  logic         evict_ready;
  logic [31:0]  evict_paddr;
  logic [255:0] evict_data;
  logic         wb_wreq;
  logic         wb_wreq_recvd;
  logic         wb_wdone;
  logic [31:0]  wb_wdata_paddr;
  logic [31:0]  wb_wdata_bank0, wb_wdata_bank1, wb_wdata_bank2, wb_wdata_bank3;
  logic [31:0]  wb_wdata_bank4, wb_wdata_bank5, wb_wdata_bank6, wb_wdata_bank7;
  logic         wb_clear;
  logic         wb_clear_done;
  logic         flush_req;
  logic         flush_done;
  logic [31:0]  fw_paddr;
  logic         fw_hit;
  logic [255:0] fw_data;

  int total = 0;
  int bad   = 0;
  int leak  = 0;
  logic in_flush = 1'b0;

  victim_stage dut (
    .clk            (clk),
    .rstn           (rstn),
    .evict_valid    (evict_valid),
    .evict_ready    (evict_ready),
    .evict_paddr    (evict_paddr),
    .evict_data     (evict_data),
    .wb_wreq        (wb_wreq),
    .wb_wreq_recvd  (wb_wreq_recvd),
    .wb_wdone       (wb_wdone),
    .wb_wdata_paddr (wb_wdata_paddr),
    .wb_wdata_bank0 (wb_wdata_bank0),
    .wb_wdata_bank1 (wb_wdata_bank1),
    .wb_wdata_bank2 (wb_wdata_bank2),
    .wb_wdata_bank3 (wb_wdata_bank3),
    .wb_wdata_bank4 (wb_wdata_bank4),
    .wb_wdata_bank5 (wb_wdata_bank5),
    .wb_wdata_bank6 (wb_wdata_bank6),
    .wb_wdata_bank7 (wb_wdata_bank7),
    .wb_clear       (wb_clear),
    .wb_clear_done  (wb_clear_done),
    .flush_req      (flush_req),
    .flush_done     (flush_done),
    .fw_paddr       (fw_paddr),
    .fw_hit         (fw_hit),
    .fw_data        (fw_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (in_flush && evict_ready) leak++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [255:0] mkline(input logic [31:0] base);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = base + k;
    return l;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] head_line();
    return {wb_wdata_bank7, wb_wdata_bank6, wb_wdata_bank5, wb_wdata_bank4,
            wb_wdata_bank3, wb_wdata_bank2, wb_wdata_bank1, wb_wdata_bank0};
  endfunction

  task automatic push(input logic [31:0] pa, input logic [31:0] base);
    evict_paddr = pa;
    evict_data  = mkline(base);
    evict_valid = 1'b1;
  endtask

  task automatic serve(input string tag, input logic [31:0] pa, input logic [255:0] line);
    int n = 0;
    while (!wb_wreq && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_wreq"}, wb_wreq, 1);
    chk({tag, "_paddr"}, wb_wdata_paddr, pa);
    chk({tag, "_data"}, head_line(), line);
    wb_wreq_recvd = 1'b1;
    tick();
    wb_wreq_recvd = 1'b0;
    repeat (2) tick();
    wb_wdone = 1'b1;
    tick();
    wb_wdone = 1'b0;
  endtask

  initial begin
    int n;
    rstn = 1'b0; evict_valid = 1'b0; evict_paddr = '0; evict_data = '0;
    wb_wreq_recvd = 1'b0; wb_wdone = 1'b0; wb_clear_done = 1'b0;
    flush_req = 1'b0; fw_paddr = '0;
    repeat (3) tick();
    chk("rst_wreq", wb_wreq, 0);
    chk("rst_clear", wb_clear, 0);
    chk("rst_fdone", flush_done, 0);
    chk("rst_fwhit", fw_hit, 0);
    chk("rst_paddr", wb_wdata_paddr, 0);
    chk("rst_bank0", wb_wdata_bank0, 0);
    rstn = 1'b1;
    #1 chk("rst_ready", evict_ready, 1);
    tick();

    // single evict, minimum latency, stray wdone in REQ ignored
    push(32'h1FC0_0020, 32'd1);
    #1 chk("t1_ready", evict_ready, 1);
    tick();
    evict_valid = 1'b0;
    chk("t1_wreq_n1", wb_wreq, 0);
    tick();
    chk("t1_wreq_n2", wb_wreq, 1);
    chk("t1_paddr", wb_wdata_paddr, 32'h1FC0_0020);
    chk("t1_bank3", wb_wdata_bank3, 4);
    chk("t1_bank7", wb_wdata_bank7, 8);
    wb_wdone = 1'b1; tick(); wb_wdone = 1'b0;
    chk("t1_stray_wdone", wb_wreq, 1);
    wb_wreq_recvd = 1'b1; tick(); wb_wreq_recvd = 1'b0;
    chk("t1_wait", wb_wreq, 0);
    repeat (4) tick();
    wb_wdone = 1'b1; tick(); wb_wdone = 1'b0;
    fw_paddr = 32'h1FC0_0020;
    #1 chk("t1_popped_fw", fw_hit, 0);
    chk("t1_paddr_clr", wb_wdata_paddr, 0);
    tick();
    chk("t1_idle", wb_wreq, 0);

    // fill: third victim stalls until first wdone
    push(32'h0000_1000, 32'h10);
    tick();
    push(32'h0000_2000, 32'h20);
    #1 chk("t2_second_ready", evict_ready, 1);
    tick();
    push(32'h0000_3000, 32'h30);
    #1 chk("t2_full", evict_ready, 0);
    chk("t2_wreq", wb_wreq, 1);
    chk("t2_head", wb_wdata_paddr, 32'h0000_1000);
    repeat (3) tick();
    chk("t2_hold", evict_ready, 0);
    wb_wreq_recvd = 1'b1; tick(); wb_wreq_recvd = 1'b0;
    chk("t2_wait_full", evict_ready, 0);
    wb_wdone = 1'b1; tick(); wb_wdone = 1'b0;
    chk("t2_freed", evict_ready, 1);
    tick();
    evict_valid = 1'b0;
    serve("t2_b", 32'h0000_2000, mkline(32'h20));
    serve("t2_c", 32'h0000_3000, mkline(32'h30));

    // merge into non-head entry; head match stalls when full
    push(32'h0000_0100, 32'h100);
    tick();
    evict_valid = 1'b0;
    tick();
    chk("t3_req", wb_wreq, 1);
    wb_wreq_recvd = 1'b1; tick(); wb_wreq_recvd = 1'b0;
    push(32'h0000_0200, 32'h200);
    tick();
    evict_data = mkline(32'h900);
    #1 chk("t3_merge_ready", evict_ready, 1);
    tick();
    push(32'h0000_0100, 32'hA00);
    #1 chk("t3_head_stall", evict_ready, 0);
    wb_wdone = 1'b1; tick(); wb_wdone = 1'b0;
    chk("t3_after_pop", evict_ready, 1);
    tick();
    evict_valid = 1'b0;
    serve("t3_merged", 32'h0000_0200, mkline(32'h900));
    serve("t3_realloc", 32'h0000_0100, mkline(32'hA00));
    chk("t3_empty", fw_hit, 0);

    // forwarding, head match in REQ allocates, younger wins
    push(32'h0000_0300, 32'h300);
    tick();
    evict_valid = 1'b0;
    fw_paddr = 32'h0000_031C;
    #1 chk("t4_hit", fw_hit, 1);
    chk("t4_data", fw_data, mkline(32'h300));
    fw_paddr = 32'h0000_0320;
    #1 chk("t4_miss", fw_hit, 0);
    chk("t4_miss_data", fw_data, 0);
    tick();
    push(32'h0000_0300, 32'hB00);
    #1 chk("t4_head_alloc", evict_ready, 1);
    tick();
    evict_valid = 1'b0;
    fw_paddr = 32'h0000_0300;
    #1 chk("t4_younger", fw_data, mkline(32'hB00));
    serve("t4_old", 32'h0000_0300, mkline(32'h300));
    chk("t4_after_pop", fw_data, mkline(32'hB00));
    serve("t4_young", 32'h0000_0300, mkline(32'hB00));
    chk("t4_gone", fw_hit, 0);

    // flush with two staged entries
    push(32'h0000_0400, 32'h40);
    tick();
    push(32'h0000_0500, 32'h50);
    tick();
    evict_valid = 1'b0;
    flush_req = 1'b1;
    in_flush  = 1'b1;
    #1 chk("t5_ready", evict_ready, 0);
    serve("t5_a", 32'h0000_0400, mkline(32'h40));
    chk("t5_noclear_mid", wb_clear, 0);
    serve("t5_b", 32'h0000_0500, mkline(32'h50));
    n = 0;
    while (!wb_clear && n < 10) begin
      tick();
      n++;
    end
    chk("t5_clear", wb_clear, 1);
    chk("t5_fdone_early", flush_done, 0);
    repeat (3) tick();
    chk("t5_clear_held", wb_clear, 1);
    wb_clear_done = 1'b1; tick(); wb_clear_done = 1'b0;
    chk("t5_fdone", flush_done, 1);
    chk("t5_clear_drop", wb_clear, 0);
    chk("t5_ready_fdone", evict_ready, 0);
    in_flush  = 1'b0;
    flush_req = 1'b0;
    tick();
    chk("t5_fdone_pulse", flush_done, 0);
    chk("t5_ready_after", evict_ready, 1);
    chk("t5_no_leak", leak, 0);

    // asynchronous reset while in REQ
    push(32'h0000_0600, 32'h60);
    tick();
    evict_valid = 1'b0;
    tick();
    chk("t6_req", wb_wreq, 1);
    #2 rstn = 1'b0;
    #1 chk("t6_async", wb_wreq, 0);
    chk("t6_paddr", wb_wdata_paddr, 0);
    fw_paddr = 32'h0000_0600;
    #1 chk("t6_fw", fw_hit, 0);
    tick();
    rstn = 1'b1;
    #1 chk("t6_ready", evict_ready, 1);
    repeat (3) tick();
    chk("t6_empty", wb_wreq, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/victim_stage.md
VICTIM_STAGE -- requirements
Module: victim_stage

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-low reset.
REQ-002 clk  in  1  sole clock, all state updates on rising edge.
REQ-003 rstn  in  1  asynchronous active-low reset.
REQ-004 evict_valid  in  1  dcache offers a dirty victim line this cycle.
REQ-005 evict_ready  out  1  stage can accept a victim this cycle.
REQ-006 evict_paddr  in  32  victim line physical address; bits [4:0] are ignored.
REQ-007 evict_data  in  256  victim line, word k at bits [32k+31:32k].
REQ-008 wb_wreq  out  1  write request to write buffer, held until wb_wreq_recvd.
REQ-009 wb_wreq_recvd  in  1  write buffer accepted the line (one-cycle pulse).
REQ-010 wb_wdone  in  1  write buffer finished storing the line (one-cycle pulse).
REQ-011 wb_wdata_paddr  out  32  head address {tag27, 5'b0}.
REQ-012 wb_wdata_bank0..7  out  32 each  head line words 0..7.
REQ-013 wb_clear / wb_clear_done  out/in  1/1  write-buffer drain request / drain complete pulse.
REQ-014 flush_req / flush_done  in/out  1/1  level flush request, held until flush_done / one-cycle completion pulse.
REQ-015 fw_paddr  in  32  refill lookup address.
REQ-016 fw_hit / fw_data  out  1/256  combinational: line present in staging queue / its data.

Function
REQ-017 Storage SHALL be a 2-entry FIFO with the following fields per entry: valid, tag[26:0], data[255:0]; head/tail are 1-bit pointers that wrap 1->0; the count is 2 bits.
REQ-018 Accept SHALL occur on evict_valid && evict_ready at the rising edge.
REQ-019 evict_ready SHALL be (count<2 || merge_ok) && !flush_req.
REQ-020 A merge SHALL occur when evict_paddr[31:5] equals the tag of a valid entry that is not the head while state!=IDLE; the merge overwrites that entry's data in place and leaves count unchanged; merge_ok denotes this condition.
REQ-021 A matching head entry while in REQ or WAIT SHALL NOT be overwritten; the victim instead allocates a new entry, or stalls if the FIFO is full.
REQ-022 The FSM SHALL have the states IDLE, REQ, WAIT, CLEAR, FDONE.
REQ-023 IDLE: count>0 -> REQ; else flush_req -> CLEAR; else stay in IDLE.
REQ-024 REQ: wb_wreq=1 with head paddr and data stable; wb_wreq_recvd -> WAIT.
REQ-025 WAIT: on wb_wdone, pop the head (clear its valid, head++, count--) and go to IDLE; wb_wdone may arrive many cycles later because the write buffer may drain to AXI in between.
REQ-026 CLEAR: wb_clear=1; wb_clear_done -> FDONE.
REQ-027 FDONE: flush_done=1 for exactly one cycle, then IDLE.
REQ-028 A push and a pop in the same cycle SHALL both take effect, leaving count unchanged.
REQ-029 Minimum latency SHALL be: accept at edge N -> wb_wreq high in cycle N+2 (IDLE sees count>0 at N+1).
REQ-030 Forwarding SHALL compare fw_paddr[31:5] with all valid entries; on a double match the younger entry wins; it is a pure combinational path with no state effect.
REQ-031 A flush SHALL drain all staged entries before asserting wb_clear; evict_ready stays 0 from flush_req until flush_done.
REQ-032 Pulses on wb_wreq_recvd outside REQ or wb_wdone outside WAIT SHALL be ignored.

Reset
REQ-033 Asserting rstn=0 at any time, including mid-transfer, SHALL clear all entry valid bits, pointers, count and FSM state (to IDLE).
REQ-034 Outputs during and after reset SHALL be: wb_wreq=0, wb_clear=0, flush_done=0, fw_hit=0, evict_ready=1 once rstn=1, paddr and data outputs 0.
REQ-035 Entry data arrays SHALL NOT require reset; only valid bits gate their use.

Structure
REQ-036 The shared dcache package SHALL hold LINE_WORDS=8, TAG_W=27, OFFSET_W=5 and the FSM state encoding.
REQ-037 The FIFO entry storage plus its match logic SHALL be one sub-module, victim_fifo; the FSM stays in victim_stage.

Verification
REQ-038 Single evict: paddr=0x1FC0_0020, data word k=k+1 -> wb_wreq rises 2 cycles later with bank3=4; recvd then wdone -> count=0, state IDLE.
REQ-039 Fill: two evicts while wb_wreq_recvd is held off -> evict_ready=0; a third evict_valid is stalled until the first wdone.
REQ-040 Merge: head 0x100 in WAIT, push 0x200, then push 0x200 again with new data -> count stays 2, second wreq carries the new data; push 0x100 again -> new entry allocated, or stall if full.
REQ-041 Forward: entry 0x300 queued, fw_paddr=0x31C -> fw_hit=1, fw_data equals staged line; fw_paddr=0x320 -> fw_hit=0.
REQ-042 Flush with 2 entries -> two wreq/wdone pairs, then wb_clear until clear_done, then flush_done high for exactly 1 cycle; evict_ready=0 throughout.
REQ-043 Reset mid-transfer: rstn low while in REQ -> wb_wreq=0 immediately; after release count=0 and evict_ready=1.
